uart_hex_tx: RTL and testbench
==============================

Name: uart_hex_tx

Overview:
Transmit-side counterpart to the board's UART receive/display path. It accepts one binary byte and sends it over UART 8N1 as human-readable ASCII hex: upper nibble character, lower nibble character, then an optional CR LF. It sits between any byte producer and the o_UART_TX pin. The host terminal therefore shows the same two hex digits the 7-segment display would show.

Parameters:
CLKS_PER_BIT, 217, clocks per UART bit (25 MHz / 115200); legal range 2..65535.
EOL_EN, 1, 1 = append CR (0x0D) then LF (0x0A) after the two hex characters; 0 = hex characters only.
UPPER_CASE, 1, 1 = A-F sent as 0x41-0x46; 0 = a-f sent as 0x61-0x66.

Ports:
i_Clk  in  1  system clock; every flop is on the rising edge.
i_Rst  in  1  synchronous, active-high reset.
i_Byte_DV  in  1  one-cycle strobe; i_Byte is valid.
i_Byte  in  8  binary byte to format and send.
o_Busy  out  1  high while a message is in flight; a strobe is accepted only when o_Busy=0.
o_Done  out  1  one-cycle pulse when the final stop bit of a message completes.
o_Drop  out  1  one-cycle pulse when i_Byte_DV arrives while o_Busy=1.
o_UART_TX  out  1  serial line, registered, idle high.

Behaviour:
- Clock and reset: one clock, i_Clk. Reset i_Rst is synchronous and active-high; these are fixed.
- Reset values: o_UART_TX=1, o_Busy=0, o_Done=0, o_Drop=0, state IDLE, all counters 0.
- Reset mid-frame: o_UART_TX returns high on the next edge. The frame is truncated, no o_Done pulse is produced, and the latched byte is discarded.
- Accept: i_Byte_DV=1 with o_Busy=0 in cycle N latches i_Byte. In cycle N+1, o_Busy=1 and o_UART_TX=0 (start bit of the first character).
- Drop: i_Byte_DV=1 with o_Busy=1 gives o_Drop=1 in the next cycle. The byte is ignored and the in-flight stream is unchanged.
- Character sequence, index 0..LAST, where LAST=3 if EOL_EN else 1:
  - index 0: hex(byte[7:4]); index 1: hex(byte[3:0]); index 2: 0x0D; index 3: 0x0A.
  - hex(n) = 0x30+n for n<=9; otherwise 0x41+(n-10), or 0x61+(n-10) when UPPER_CASE=0.
- Frame: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- Character spacing: no idle gap between characters. The next start bit follows the last stop-bit cycle directly.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on accept; load character 0.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits; bit index 0..7.
  - STOP, last character -> IDLE. In the same edge: o_Done=1 and o_Busy=0.
  - STOP, otherwise -> START; index+1 and load the next character.
- Busy duration: exactly (LAST+1)*10*CLKS_PER_BIT cycles.
- Back-to-back: a strobe in the o_Done cycle (o_Busy=0) is accepted. Its start bit then follows that cycle with zero extra idle beyond it.
- Width rules:
  - Baud counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - Bit index is 3 bits; character index is 2 bits.

Decomposition:
- Shared package (uart_pkg) holds:
  - ASCII constants: ASCII_0=0x30, ASCII_UA=0x41, ASCII_LA=0x61, ASCII_CR=0x0D, ASCII_LF=0x0A.
  - The tx state enum (IDLE/START/DATA/STOP).
  - The nibble-to-ASCII function.
- One natural sub-module: uart_tx_serializer, an 8N1 bit engine with a load/ready handshake. uart_hex_tx sequences the characters into it and owns accept/drop/done.

Test Plan:
1. CLKS_PER_BIT=4, EOL_EN=1, UPPER_CASE=1; DV with i_Byte=0x3A -> line carries 0x33, 0x41, 0x0D, 0x0A. o_Busy is high for 160 cycles, then a single o_Done pulse.
2. i_Byte=0xFF, UPPER_CASE=0, EOL_EN=0 -> 0x66, 0x66 sent; busy 80 cycles. i_Byte=0x09 -> 0x30, 0x39 sent.
3. DV 0x12 accepted, then DV 0x34 at cycle 30 -> o_Drop pulses one cycle later. Line still carries 0x31, 0x32, 0x0D, 0x0A; no second message follows.
4. DV 0xA5 issued in the o_Done cycle of a prior message -> the next cycle is a start bit with no idle high gap; decoded stream is 0x41, 0x35, 0x0D, 0x0A.
5. i_Rst=1 during the DATA bits of character 1 -> next cycle o_UART_TX=1, o_Busy=0, no o_Done. A DV afterwards sends a fresh, complete message.
6. Post-reset idle for 1000 cycles with no DV -> o_UART_TX stays 1 and o_Busy, o_Done and o_Drop stay 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared ASCII constants, tx state enum and nibble-to-ASCII helper
package uart_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n, input logic upper);
        if (n <= 4'd9) begin
            return ASCII_0 + {4'h0, n};
        end
        return (upper ? ASCII_UA : ASCII_LA) + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_hex_tx_if.sv
// rtl/uart_hex_tx_if.sv - byte strobe in, status pulses and serial line out
interface uart_hex_tx_if;

    logic       i_Byte_DV;
    logic [7:0] i_Byte;
    logic       o_Busy;
    logic       o_Done;
    logic       o_Drop;
    logic       o_UART_TX;

    modport master (
        output i_Byte_DV,
        output i_Byte,
        input  o_Busy,
        input  o_Done,
        input  o_Drop,
        input  o_UART_TX
    );

    modport slave (
        input  i_Byte_DV,
        input  i_Byte,
        output o_Busy,
        output o_Done,
        output o_Drop,
        output o_UART_TX
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 bit engine; load is taken when idle or in the last stop-bit cycle
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       frame_end,
    output logic       tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e      state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           bit_end;

    assign bit_end   = (baud_cnt == CNT_MAX);
    assign frame_end = (state == STOP) && bit_end;
    // Accepting during the final stop cycle is what makes characters abut with no gap.
    assign ready     = (state == IDLE) || frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    if (load) begin
                        state <= START;
                        shreg <= data;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (load) begin
                            state <= START;
                            shreg <= data;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_hex_tx.sv
// rtl/uart_hex_tx.sv - sends a byte as two ASCII hex characters (plus optional CR LF) over UART 8N1
module uart_hex_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int EOL_EN       = 1,
    parameter int UPPER_CASE   = 1
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    uart_hex_tx_if.slave     bus
);

    localparam logic [1:0] LAST  = (EOL_EN != 0) ? 2'd3 : 2'd1;
    localparam logic       UPPER = (UPPER_CASE != 0);

    function automatic logic [7:0] char_at(input logic [7:0] b, input logic [1:0] idx);
        case (idx)
            2'd0:    return nibble_to_ascii(b[7:4], UPPER);
            2'd1:    return nibble_to_ascii(b[3:0], UPPER);
            2'd2:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

    logic [7:0] data_q;
    logic [1:0] idx_q;
    logic       busy_q;
    logic       done_q;
    logic       drop_q;
    logic       accept;
    logic       more;
    logic       ser_load;
    logic [7:0] ser_data;
    logic       ser_ready;
    logic       ser_frame_end;
    logic       ser_tx;

    assign accept   = bus.i_Byte_DV && !busy_q && ser_ready;
    assign more     = ser_frame_end && (idx_q != LAST);
    assign ser_load = accept || more;

    // The first character comes straight from the input since the byte is latched on the same edge.
    always_comb begin
        ser_data = char_at(data_q, idx_q + 2'd1);
        if (accept) begin
            ser_data = char_at(bus.i_Byte, 2'd0);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            data_q <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            drop_q <= bus.i_Byte_DV && busy_q;
            if (accept) begin
                data_q <= bus.i_Byte;
                idx_q  <= 2'd0;
                busy_q <= 1'b1;
            end else if (ser_frame_end) begin
                if (idx_q == LAST) begin
                    idx_q  <= 2'd0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + 2'd1;
                end
            end
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk       (i_Clk),
        .rst       (i_Rst),
        .load      (ser_load),
        .data      (ser_data),
        .ready     (ser_ready),
        .frame_end (ser_frame_end),
        .tx        (ser_tx)
    );

    assign bus.o_Busy    = busy_q;
    assign bus.o_Done    = done_q;
    assign bus.o_Drop    = drop_q;
    assign bus.o_UART_TX = ser_tx;

endmodule

// File: tb/tb_uart_hex_tx.sv
// tb/tb_uart_hex_tx.sv - directed vector bench for uart_hex_tx with a UART line decoder
module tb_uart_hex_tx;

    localparam int C = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_hex_tx_if bus_a();
    uart_hex_tx_if bus_b();

    uart_hex_tx #(.CLKS_PER_BIT(C), .EOL_EN(1), .UPPER_CASE(1)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .bus(bus_a)
    );
    uart_hex_tx #(.CLKS_PER_BIT(C), .EOL_EN(0), .UPPER_CASE(0)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .bus(bus_b)
    );

    wire [1:0] tx_w   = {bus_b.o_UART_TX, bus_a.o_UART_TX};
    wire [1:0] busy_w = {bus_b.o_Busy, bus_a.o_Busy};
    wire [1:0] done_w = {bus_b.o_Done, bus_a.o_Done};
    wire [1:0] drop_w = {bus_b.o_Drop, bus_a.o_Drop};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line receiver: samples each bit mid-way, counting from the first low sample of the start bit.
    bit         dec_act[2]  = '{0, 0};
    int         dec_cnt[2]  = '{0, 0};
    logic [7:0] dec_sh[2];
    int         done_cnt[2] = '{0, 0};
    int         busy_run[2] = '{0, 0};
    int         last_busy[2] = '{0, 0};
    logic [7:0] rxq_a[$];
    logic [7:0] rxq_b[$];

    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (rst) begin
                dec_act[l]  = 1'b0;
                busy_run[l] = 0;
            end else begin
                if (busy_w[l]) busy_run[l]++;
                if (done_w[l]) begin
                    last_busy[l] = busy_run[l];
                    busy_run[l]  = 0;
                    done_cnt[l]++;
                end
                if (!dec_act[l]) begin
                    if (tx_w[l] == 1'b0) begin
                        dec_act[l] = 1'b1;
                        dec_cnt[l] = 0;
                    end
                end else begin
                    dec_cnt[l]++;
                    if (dec_cnt[l] == C/2) check($sformatf("start_bit_line%0d", l), tx_w[l], 0);
                    for (int k = 1; k <= 8; k++) begin
                        if (dec_cnt[l] == k*C + C/2) dec_sh[l][k-1] = tx_w[l];
                    end
                    if (dec_cnt[l] == 9*C + C/2) begin
                        check($sformatf("stop_bit_line%0d", l), tx_w[l], 1);
                        if (l == 0) rxq_a.push_back(dec_sh[l]);
                        else        rxq_b.push_back(dec_sh[l]);
                        dec_act[l] = 1'b0;
                    end
                end
            end
        end
    end

    typedef struct {
        int         line;
        logic [7:0] data;
        int         n;
        logic [7:0] ch[4];
        int         busy;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] expq[$];

    task automatic add_vec(input int line, input logic [7:0] d, input int n,
                           input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3, input int busy);
        vec_t v;
        v.line = line; v.data = d; v.n = n;
        v.ch[0] = c0; v.ch[1] = c1; v.ch[2] = c2; v.ch[3] = c3;
        v.busy = busy;
        vq.push_back(v);
    endtask

    task automatic clear_q(input int l);
        if (l == 0) rxq_a.delete();
        else        rxq_b.delete();
    endtask

    task automatic check_msg(input string name, input int l);
        int sz;
        logic [7:0] got;
        sz = (l == 0) ? rxq_a.size() : rxq_b.size();
        check({name, "_nchars"}, sz, expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            got = 8'hEE;
            if (i < sz) got = (l == 0) ? rxq_a[i] : rxq_b[i];
            check($sformatf("%s_char%0d", name, i), {24'h0, got}, {24'h0, expq[i]});
        end
    endtask

    task automatic send(input int l, input logic [7:0] d);
        @(posedge clk); #1;
        if (l == 0) begin bus_a.i_Byte = d; bus_a.i_Byte_DV = 1'b1; end
        else        begin bus_b.i_Byte = d; bus_b.i_Byte_DV = 1'b1; end
        @(posedge clk); #1;
        bus_a.i_Byte_DV = 1'b0;
        bus_b.i_Byte_DV = 1'b0;
    endtask

    task automatic wait_done(input string name, input int l, input int d0);
        for (int i = 0; i < 2000 && done_cnt[l] == d0; i++) @(negedge clk);
        check({name, "_done_seen"}, done_cnt[l] != d0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit bad_tx, bad_busy, bad_done, bad_drop;
        vec_t v;

        bus_a.i_Byte_DV = 1'b0; bus_a.i_Byte = 8'h00;
        bus_b.i_Byte_DV = 1'b0; bus_b.i_Byte = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("reset_tx%0d", l),   tx_w[l],   1);
            check($sformatf("reset_busy%0d", l), busy_w[l], 0);
            check($sformatf("reset_done%0d", l), done_w[l], 0);
            check($sformatf("reset_drop%0d", l), drop_w[l], 0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // Long idle after reset: the line must stay quiet.
        bad_tx = 0; bad_busy = 0; bad_done = 0; bad_drop = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx_w != 2'b11)   bad_tx   = 1;
            if (busy_w != 2'b00) bad_busy = 1;
            if (done_w != 2'b00) bad_done = 1;
            if (drop_w != 2'b00) bad_drop = 1;
        end
        check("idle_tx_high",  bad_tx,   0);
        check("idle_busy_low", bad_busy, 0);
        check("idle_done_low", bad_done, 0);
        check("idle_drop_low", bad_drop, 0);

        add_vec(0, 8'h3A, 4, 8'h33, 8'h41, 8'h0D, 8'h0A, 160);
        add_vec(1, 8'hFF, 2, 8'h66, 8'h66, 8'h00, 8'h00, 80);
        add_vec(1, 8'h09, 2, 8'h30, 8'h39, 8'h00, 8'h00, 80);
        add_vec(0, 8'h00, 4, 8'h30, 8'h30, 8'h0D, 8'h0A, 160);
        add_vec(1, 8'hC7, 2, 8'h63, 8'h37, 8'h00, 8'h00, 80);
        add_vec(0, 8'h5F, 4, 8'h35, 8'h46, 8'h0D, 8'h0A, 160);

        for (int vi = 0; vi < vq.size(); vi++) begin
            v = vq[vi];
            d0 = done_cnt[v.line];
            clear_q(v.line);
            send(v.line, v.data);
            wait_done($sformatf("vec%0d", vi), v.line, d0);
            repeat (20) @(negedge clk);
            expq.delete();
            for (int i = 0; i < v.n; i++) expq.push_back(v.ch[i]);
            check_msg($sformatf("vec%0d", vi), v.line);
            check($sformatf("vec%0d_busy_len", vi), last_busy[v.line], v.busy);
            check($sformatf("vec%0d_done_pulses", vi), done_cnt[v.line] - d0, 1);
        end

        // Strobe while busy is dropped and does not disturb the message.
        d0 = done_cnt[0];
        clear_q(0);
        send(0, 8'h12);
        @(negedge clk);
        check("accept_busy", bus_a.o_Busy, 1);
        check("accept_start_bit", bus_a.o_UART_TX, 0);
        repeat (28) @(posedge clk);
        #1 bus_a.i_Byte = 8'h34; bus_a.i_Byte_DV = 1'b1;
        @(negedge clk);
        check("drop_not_early", bus_a.o_Drop, 0);
        @(posedge clk); #1 bus_a.i_Byte_DV = 1'b0;
        @(negedge clk);
        check("drop_pulse", bus_a.o_Drop, 1);
        @(negedge clk);
        check("drop_one_cycle", bus_a.o_Drop, 0);
        wait_done("drop", 0, d0);
        repeat (200) @(negedge clk);
        expq = '{8'h31, 8'h32, 8'h0D, 8'h0A};
        check_msg("drop", 0);
        check("drop_done_pulses", done_cnt[0] - d0, 1);

        // New strobe in the done cycle starts the next message immediately.
        d0 = done_cnt[0];
        clear_q(0);
        send(0, 8'h00);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 2000 && !seen; i++) begin
                @(negedge clk);
                if (bus_a.o_Done) seen = 1;
            end
            check("b2b_done_seen", seen, 1);
            check("b2b_done_busy_low", bus_a.o_Busy, 0);
            bus_a.i_Byte = 8'hA5; bus_a.i_Byte_DV = 1'b1;
            @(posedge clk); #1 bus_a.i_Byte_DV = 1'b0;
            @(negedge clk);
            check("b2b_start_bit", bus_a.o_UART_TX, 0);
            check("b2b_busy", bus_a.o_Busy, 1);
        end
        wait_done("b2b", 0, d0 + 1);
        repeat (20) @(negedge clk);
        expq = '{8'h30, 8'h30, 8'h0D, 8'h0A, 8'h41, 8'h35, 8'h0D, 8'h0A};
        check_msg("b2b", 0);
        check("b2b_done_pulses", done_cnt[0] - d0, 2);

        // Reset during the data bits of the second character.
        d0 = done_cnt[0];
        clear_q(0);
        send(0, 8'h3A);
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_tx", bus_a.o_UART_TX, 1);
        check("rst_mid_busy", bus_a.o_Busy, 0);
        clear_q(0);
        repeat (300) @(negedge clk);
        check("rst_mid_no_done", done_cnt[0] - d0, 0);
        check("rst_mid_no_chars", rxq_a.size(), 0);
        check("rst_mid_line_idle", bus_a.o_UART_TX, 1);
        d0 = done_cnt[0];
        send(0, 8'h5F);
        wait_done("post_rst", 0, d0);
        repeat (20) @(negedge clk);
        expq = '{8'h35, 8'h46, 8'h0D, 8'h0A};
        check_msg("post_rst", 0);
        check("post_rst_busy_len", last_busy[0], 160);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
